// File: rtl/pdp8_bus_ctrl.sv
// PDP-8 nibble-bus controller: decodes CPU bus beats into memory/IO accesses
// and arbitrates memory ownership between the CPU and an external loader.
module pdp8_bus_ctrl #(
    parameter int unsigned LD_MAX_CYC = 4095
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  cpu_bus,
    output logic [3:0]  cpu_din,
    output logic        cpu_reset,
    output logic [11:0] mem_addr,
    output logic        mem_re,
    output logic        mem_we,
    output logic [11:0] mem_wdata,
    input  logic [11:0] mem_rdata,
    output logic [4:0]  io_sel,
    input  logic [2:0]  io_status,
    output logic        io_we,
    output logic [11:0] io_wdata,
    input  logic [11:0] io_rdata,
    input  logic        ld_req,
    output logic        ld_gnt,
    input  logic [11:0] ld_addr,
    input  logic [11:0] ld_wdata,
    input  logic        ld_we,
    output logic [11:0] ld_rdata
);
    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_LOAD, S_RELEASE} state_t;

    localparam logic [11:0] MAX12 = 12'(LD_MAX_CYC);
    localparam logic [12:0] MAX13 = 13'(LD_MAX_CYC);

    state_t      r_state, w_state_nx;
    logic        r_ld_gnt, r_cpu_reset;
    logic [5:0]  r_addr_hi;
    logic [11:0] r_addr_reg, r_rd_buf, r_cnt;
    logic        r_rd_pend, r_io_mark;
    logic [3:0]  r_nib_h, r_nib_m;
    logic [4:0]  r_io_sel;

    logic w_addr_h, w_addr_l, w_io_intro, w_data_h, w_data_m, w_data_l, w_wr;
    logic w_cpu_en, w_ld_en, w_cnt_done;
    logic [11:0] w_wdata, w_rd_word, w_src;

    assign w_addr_h   = (cpu_bus[7:6] == 2'b10);
    assign w_addr_l   = (cpu_bus[7:6] == 2'b11);
    assign w_io_intro = (cpu_bus[7:5] == 3'b011);
    assign w_data_h   = (cpu_bus[7:5] == 3'b000);
    assign w_data_m   = (cpu_bus[7:5] == 3'b001);
    assign w_data_l   = (cpu_bus[7:5] == 3'b010);
    assign w_wr       = cpu_bus[4];

    assign w_cpu_en   = reset_n && (r_state == S_RUN || r_state == S_DRAIN);
    assign w_ld_en    = reset_n && (r_state == S_LOAD);
    assign w_cnt_done = ({1'b0, r_cnt} + 13'd1) >= MAX13;

    assign w_wdata   = {r_nib_h, r_nib_m, cpu_bus[3:0]};
    // Read data arrives the cycle after mem_re, i.e. on DATA_H; bypass rd_buf then.
    assign w_rd_word = r_rd_pend ? mem_rdata : r_rd_buf;
    assign w_src     = r_io_mark ? io_rdata : w_rd_word;

    assign mem_re    = (w_cpu_en && w_addr_l && !r_io_mark) || (w_ld_en && !ld_we);
    assign mem_we    = (w_cpu_en && w_data_l && w_wr && !r_io_mark) || (w_ld_en && ld_we);
    assign mem_wdata = (r_state == S_LOAD) ? ld_wdata : w_wdata;
    assign io_we     = w_cpu_en && w_data_l && w_wr && r_io_mark;
    assign io_wdata  = w_wdata;
    assign io_sel    = r_io_sel;
    assign ld_rdata  = w_rd_word;
    assign ld_gnt    = r_ld_gnt && reset_n;
    assign cpu_reset = r_cpu_reset || !reset_n;

    always_comb begin
        mem_addr = r_addr_reg;
        if (r_state == S_LOAD)
            mem_addr = ld_addr;
        else if (w_addr_l)
            mem_addr = {r_addr_hi, cpu_bus[5:0]};
    end

    always_comb begin
        cpu_din = '0;
        if (w_cpu_en) begin
            if (w_io_intro)
                cpu_din = {1'b0, io_status};
            else if (!w_wr && w_data_h)
                cpu_din = w_src[11:8];
            else if (!w_wr && w_data_m)
                cpu_din = w_src[7:4];
            else if (!w_wr && w_data_l)
                cpu_din = w_src[3:0];
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_RUN:     if (ld_req) w_state_nx = S_DRAIN;
            S_DRAIN:   if (w_data_l) w_state_nx = S_LOAD;
            S_LOAD:    if (!ld_req || w_cnt_done) w_state_nx = S_RELEASE;
            S_RELEASE: w_state_nx = S_RUN;
            default:   w_state_nx = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= S_RUN;
            r_ld_gnt    <= 1'b0;
            r_cpu_reset <= 1'b0;
            r_addr_hi   <= '0;
            r_addr_reg  <= '0;
            r_rd_buf    <= '0;
            r_rd_pend   <= 1'b0;
            r_cnt       <= '0;
            r_io_mark   <= 1'b0;
            r_io_sel    <= '0;
            r_nib_h     <= '0;
            r_nib_m     <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_ld_gnt    <= (w_state_nx == S_LOAD);
            r_cpu_reset <= (w_state_nx == S_LOAD) || (w_state_nx == S_RELEASE);
            r_rd_pend   <= mem_re;
            if (r_rd_pend)
                r_rd_buf <= mem_rdata;
            if (r_state != S_LOAD)
                r_cnt <= '0;
            else if (r_cnt != MAX12)
                r_cnt <= r_cnt + 12'd1;
            if (w_cpu_en) begin
                if (w_addr_h) begin
                    r_addr_hi <= cpu_bus[5:0];
                    r_io_mark <= 1'b0;
                end
                if (w_addr_l)
                    r_addr_reg <= {r_addr_hi, cpu_bus[5:0]};
                if (w_io_intro) begin
                    r_io_sel  <= cpu_bus[4:0];
                    r_io_mark <= 1'b1;
                end
                if (w_data_h && w_wr)
                    r_nib_h <= cpu_bus[3:0];
                if (w_data_m && w_wr)
                    r_nib_m <= cpu_bus[3:0];
            end
        end
    end
endmodule

// File: tb/tb_pdp8_bus_ctrl.sv
// Directed bench for pdp8_bus_ctrl: CPU memory/IO beats, loader arbitration,
// forced release (second instance with LD_MAX_CYC=3) and reset mid-load.
module tb_pdp8_bus_ctrl;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  cpu_bus;
    logic [3:0]  cpu_din;
    logic        cpu_reset;
    logic [11:0] mem_addr, mem_wdata, mem_rdata, io_wdata, io_rdata, ld_addr, ld_wdata, ld_rdata;
    logic        mem_re, mem_we, io_we, ld_req, ld_gnt, ld_we;
    logic [4:0]  io_sel;
    logic [2:0]  io_status;

    logic [7:0]  cpu_bus2;
    logic        ld_req2;
    logic [3:0]  cpu_din2;
    logic        cpu_reset2, mem_re2, mem_we2, io_we2, ld_gnt2;
    logic [11:0] mem_addr2, mem_wdata2, io_wdata2, ld_rdata2;
    logic [4:0]  io_sel2;
    logic [11:0] zero12 = 12'h000;

    logic [11:0] mem [0:4095];
    logic [11:0] mem_rdata_q;
    int          we_cnt = 0;
    int          iowe_cnt = 0;
    int          ncmp = 0;
    int          nerr = 0;

    always #5 clk = ~clk;

    pdp8_bus_ctrl dut (
        .clk(clk), .reset_n(reset_n), .cpu_bus(cpu_bus), .cpu_din(cpu_din),
        .cpu_reset(cpu_reset), .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .io_sel(io_sel), .io_status(io_status),
        .io_we(io_we), .io_wdata(io_wdata), .io_rdata(io_rdata), .ld_req(ld_req),
        .ld_gnt(ld_gnt), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_we(ld_we),
        .ld_rdata(ld_rdata)
    );

    pdp8_bus_ctrl #(.LD_MAX_CYC(3)) dut2 (
        .clk(clk), .reset_n(reset_n), .cpu_bus(cpu_bus2), .cpu_din(cpu_din2),
        .cpu_reset(cpu_reset2), .mem_addr(mem_addr2), .mem_re(mem_re2), .mem_we(mem_we2),
        .mem_wdata(mem_wdata2), .mem_rdata(zero12), .io_sel(io_sel2), .io_status(3'b000),
        .io_we(io_we2), .io_wdata(io_wdata2), .io_rdata(zero12), .ld_req(ld_req2),
        .ld_gnt(ld_gnt2), .ld_addr(zero12), .ld_wdata(zero12), .ld_we(1'b0),
        .ld_rdata(ld_rdata2)
    );

    // Synchronous memory: data returned the cycle after mem_re.
    always @(posedge clk) begin
        if (!reset_n) mem[12'h5A3] <= 12'hC3F;
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            we_cnt <= we_cnt + 1;
        end
        if (mem_re) mem_rdata_q <= mem[mem_addr];
        if (io_we) iowe_cnt <= iowe_cnt + 1;
    end
    assign mem_rdata = mem_rdata_q;
    assign io_rdata  = (io_sel == 5'd5) ? 12'h9E5 : 12'h000;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk12(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [7:0] b);
        @(negedge clk);
        cpu_bus = b;
        #2;
    endtask

    initial begin
        int w0;
        int g;
        logic [6:0] exp_g;
        logic [6:0] exp_r;
        reset_n = 1'b0; cpu_bus = 8'h00; ld_req = 1'b0; ld_we = 1'b0;
        ld_addr = 12'h000; ld_wdata = 12'h000; io_status = 3'b000;
        ld_req2 = 1'b0; cpu_bus2 = 8'h40;

        // Reset state
        @(negedge clk); #2;
        chk1("rst_cpu_reset", cpu_reset, 1'b1);
        chk1("rst_mem_re", mem_re, 1'b0);
        chk1("rst_mem_we", mem_we, 1'b0);
        chk1("rst_io_we", io_we, 1'b0);
        chk1("rst_ld_gnt", ld_gnt, 1'b0);
        chk4("rst_cpu_din", cpu_din, 4'h0);
        chk12("rst_io_sel", {7'd0, io_sel}, 12'h000);
        chk12("rst_mem_addr", mem_addr, 12'h000);
        @(negedge clk); reset_n = 1'b1; #2;
        chk1("rst_release_cpu_reset", cpu_reset, 1'b0);

        // Memory read of 0x5A3
        beat(8'h96);
        beat(8'hE3);
        chk1("rd_mem_re", mem_re, 1'b1);
        chk12("rd_mem_addr", mem_addr, 12'h5A3);
        chk1("rd_no_we", mem_we, 1'b0);
        beat(8'h00);
        chk4("rd_din_h", cpu_din, 4'hC);
        chk1("rd_re_once", mem_re, 1'b0);
        beat(8'h20);
        chk4("rd_din_m", cpu_din, 4'h3);
        beat(8'h40);
        chk4("rd_din_l", cpu_din, 4'hF);
        chk1("rd_l_no_we", mem_we, 1'b0);

        // Memory write 0x123 at 0x7FF
        beat(8'h9F);
        beat(8'hFF);
        chk12("wr_addr_l", mem_addr, 12'h7FF);
        w0 = we_cnt;
        beat(8'h11);
        chk1("wr_h_no_we", mem_we, 1'b0);
        beat(8'h32);
        chk1("wr_m_no_we", mem_we, 1'b0);
        beat(8'h53);
        chk1("wr_l_we", mem_we, 1'b1);
        chk12("wr_wdata", mem_wdata, 12'h123);
        chk12("wr_addr", mem_addr, 12'h7FF);
        chk1("wr_l_no_re", mem_re, 1'b0);
        beat(8'h00);
        chk12("wr_we_count", 12'(we_cnt - w0), 12'h001);
        chk12("wr_mem_content", mem[12'h7FF], 12'h123);

        // IO intro, IO write 0xABC, IO read
        io_status = 3'b011;
        beat(8'h80);
        beat(8'h65);
        chk4("io_status_din", cpu_din, 4'h3);
        chk1("io_intro_no_re", mem_re, 1'b0);
        w0 = iowe_cnt;
        beat(8'h1A);
        chk12("io_sel", {7'd0, io_sel}, 12'h005);
        chk1("io_h_no_iowe", io_we, 1'b0);
        beat(8'h3B);
        beat(8'h5C);
        chk1("io_we", io_we, 1'b1);
        chk12("io_wdata", io_wdata, 12'hABC);
        chk1("io_wr_no_mem_we", mem_we, 1'b0);
        chk1("io_wr_no_mem_re", mem_re, 1'b0);
        beat(8'h65);
        beat(8'h00);
        chk4("io_rd_h", cpu_din, 4'h9);
        beat(8'h20);
        chk4("io_rd_m", cpu_din, 4'hE);
        beat(8'h40);
        chk4("io_rd_l", cpu_din, 4'h5);
        chk1("io_rd_no_re", mem_re, 1'b0);
        beat(8'h80);
        beat(8'hC0);
        chk1("io_mark_cleared_re", mem_re, 1'b1);
        chk12("io_mark_cleared_addr", mem_addr, 12'h000);
        chk12("io_we_count", 12'(iowe_cnt - w0), 12'h001);

        // Loader: request on DATA_M, drain to DATA_L, write then read back
        beat(8'h80);
        beat(8'hC1);
        beat(8'h00);
        @(negedge clk); cpu_bus = 8'h20; ld_req = 1'b1; #2;
        chk1("ld_run_gnt", ld_gnt, 1'b0);
        beat(8'h40);
        chk1("ld_drain_gnt", ld_gnt, 1'b0);
        chk1("ld_drain_cpu_reset", cpu_reset, 1'b0);
        @(negedge clk); cpu_bus = 8'h00; ld_we = 1'b1; ld_addr = 12'h000; ld_wdata = 12'h777; #2;
        chk1("ld_load_gnt", ld_gnt, 1'b1);
        chk1("ld_load_cpu_reset", cpu_reset, 1'b1);
        chk1("ld_wr_we", mem_we, 1'b1);
        chk1("ld_wr_no_re", mem_re, 1'b0);
        chk12("ld_wr_addr", mem_addr, 12'h000);
        chk12("ld_wr_wdata", mem_wdata, 12'h777);
        chk4("ld_cpu_din_quiet", cpu_din, 4'h0);
        @(negedge clk); ld_we = 1'b0; #2;
        chk1("ld_rd_re", mem_re, 1'b1);
        chk1("ld_rd_no_we", mem_we, 1'b0);
        @(negedge clk); ld_req = 1'b0; #2;
        chk12("ld_rdata", ld_rdata, 12'h777);
        chk1("ld_last_gnt", ld_gnt, 1'b1);
        @(negedge clk); ld_we = 1'b1; cpu_bus = 8'hC5; #2;
        chk1("rel_gnt", ld_gnt, 1'b0);
        chk1("rel_cpu_reset", cpu_reset, 1'b1);
        chk1("rel_no_we", mem_we, 1'b0);
        chk1("rel_no_re", mem_re, 1'b0);
        @(negedge clk); cpu_bus = 8'h00; #2;
        chk1("run_cpu_reset", cpu_reset, 1'b0);
        chk1("run_gnt", ld_gnt, 1'b0);
        chk1("run_ignores_ld_we", mem_we, 1'b0);

        // Reset in the middle of LOAD
        @(negedge clk); cpu_bus = 8'h40; ld_req = 1'b1; ld_we = 1'b0; #2;
        @(negedge clk); #2;
        @(negedge clk); #2;
        chk1("mid_load_gnt", ld_gnt, 1'b1);
        @(negedge clk); reset_n = 1'b0; #2;
        chk1("mid_rst_gnt", ld_gnt, 1'b0);
        chk1("mid_rst_cpu_reset", cpu_reset, 1'b1);
        chk1("mid_rst_no_re", mem_re, 1'b0);
        @(negedge clk); reset_n = 1'b1; ld_req = 1'b0; cpu_bus = 8'hC7; #2;
        chk1("post_rst_gnt", ld_gnt, 1'b0);
        chk1("post_rst_cpu_reset", cpu_reset, 1'b0);
        chk1("post_rst_re", mem_re, 1'b1);
        chk12("post_rst_addr", mem_addr, 12'h007);

        // Forced release on the LD_MAX_CYC=3 instance
        exp_g = 7'b0011100;
        exp_r = 7'b0111100;
        g = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i == 0) ld_req2 = 1'b1;
            if (i == 6) ld_req2 = 1'b0;
            #2;
            chk1($sformatf("fr_gnt_%0d", i), ld_gnt2, exp_g[i]);
            chk1($sformatf("fr_cpu_reset_%0d", i), cpu_reset2, exp_r[i]);
            if (ld_gnt2) g++;
        end
        chk12("fr_gnt_cycles", 12'(g), 12'h003);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
